// File: rtl/sc_spi_seq.sv
// sc_spi_seq - multi-frame SPI transaction sequencer.
// Runs one host transaction as NFRAME+1 back-to-back frames in front of the
// SPI protocol engine. For each frame it pulls a TX word from a valid/ready
// stream, pulses SPISTART and holds CSEXTEND so chip select stays low between
// frames. Each received word is forwarded, and DONE marks the end.
//
// Ports:
//   SPICLK, SYSRSTB          clock (posedge) and async active-low reset
//   REQ, NFRAME, FBITS       transaction request, frames-1, bits-per-frame-1
//   ACK, BUSY, DONE          accept pulse, transaction busy, completion pulse
//   ABORT, ABORTED           stop after current frame / DONE qualifier
//   TXVALID, TXWDATA, TXREADY   TX word stream (TXREADY is combinational)
//   RXOVALID, RXODATA        forwarded RX words (no backpressure)
//   SPISTART, CSEXTEND, TXDATA, DWIDTH   commands to the engine
//   SPIBUSY, RXDATA, RXVALID status/data from the engine

module sc_spi_seq #(
  parameter int unsigned NFW = 8
) (
  input  logic           SPICLK,
  input  logic           SYSRSTB,
  input  logic           REQ,
  input  logic [NFW-1:0] NFRAME,
  input  logic [4:0]     FBITS,
  output logic           ACK,
  output logic           BUSY,
  output logic           DONE,
  input  logic           ABORT,
  output logic           ABORTED,
  input  logic           TXVALID,
  input  logic [31:0]    TXWDATA,
  output logic           TXREADY,
  output logic           RXOVALID,
  output logic [31:0]    RXODATA,
  output logic           SPISTART,
  input  logic           SPIBUSY,
  output logic           CSEXTEND,
  output logic [31:0]    TXDATA,
  output logic [8:0]     DWIDTH,
  input  logic [31:0]    RXDATA,
  input  logic           RXVALID
);

  // Counters are one bit wider than NFRAME so 2^NFW frames never wrap.
  localparam int unsigned CW = NFW + 1;
  localparam int unsigned FW = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WBSY  = 3'd3,
    S_RUN   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   txcnt;
  logic [CW-1:0]   rxcnt;
  logic [NFW-1:0]  nframe_q;
  logic [FW-1:0]   fbits_q;
  logic            abort_flag;

  logic [CW-1:0]   last_idx;
  logic            last_frame;
  logic            drained;

  // Index of the final frame, compared against the frame currently issued.
  assign last_idx   = {1'b0, nframe_q};
  assign last_frame = (txcnt == last_idx);
  assign drained    = (rxcnt == txcnt);

  // A TX word is consumed only in FETCH, and never when ABORT is present.
  assign TXREADY = (state == S_FETCH) && TXVALID && !ABORT;

  // The engine gets the latched frame width, zero-extended.
  assign DWIDTH = {4'b0000, fbits_q};

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state      <= S_IDLE;
      txcnt      <= '0;
      rxcnt      <= '0;
      nframe_q   <= '0;
      fbits_q    <= '0;
      abort_flag <= 1'b0;
      ACK        <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ABORTED    <= 1'b0;
      RXOVALID   <= 1'b0;
      RXODATA    <= '0;
      SPISTART   <= 1'b0;
      CSEXTEND   <= 1'b0;
      TXDATA     <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      ACK      <= 1'b0;
      DONE     <= 1'b0;
      ABORTED  <= 1'b0;
      SPISTART <= 1'b0;
      RXOVALID <= 1'b0;

      // RX forwarding runs in every active state, including DRAIN.
      if ((state != S_IDLE) && RXVALID) begin
        RXODATA  <= RXDATA;
        RXOVALID <= 1'b1;
        rxcnt    <= rxcnt + CW'(1);
      end

      case (state)
        S_IDLE: begin
          // BUSY stays high through the DONE cycle and drops one cycle later.
          BUSY <= 1'b0;
          if (REQ && !SPIBUSY) begin
            nframe_q   <= NFRAME;
            fbits_q    <= FBITS;
            txcnt      <= '0;
            rxcnt      <= '0;
            abort_flag <= 1'b0;
            ACK        <= 1'b1;
            BUSY       <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (ABORT) begin
            abort_flag <= 1'b1;
            state      <= S_DRAIN;
          end else if (TXVALID) begin
            // SPISTART and CSEXTEND are registered here so that they are
            // valid for exactly the START cycle.
            TXDATA   <= TXWDATA;
            SPISTART <= 1'b1;
            CSEXTEND <= !last_frame && !abort_flag;
            state    <= S_START;
          end
        end

        S_START: begin
          if (ABORT) begin
            abort_flag <= 1'b1;
          end
          state <= S_WBSY;
        end

        S_WBSY: begin
          if (ABORT) begin
            abort_flag <= 1'b1;
          end
          if (SPIBUSY) begin
            state <= S_RUN;
          end
        end

        S_RUN: begin
          if (ABORT) begin
            abort_flag <= 1'b1;
          end
          if (!SPIBUSY) begin
            txcnt <= txcnt + CW'(1);
            if (last_frame || abort_flag || ABORT) begin
              state <= S_DRAIN;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_DRAIN: begin
          if (drained) begin
            DONE       <= 1'b1;
            ABORTED    <= abort_flag;
            CSEXTEND   <= 1'b0;
            abort_flag <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_spi_seq.sv
// tb_sc_spi_seq - randomized self-checking bench for sc_spi_seq.
// A behavioural SPI engine and TX word source drive the DUT; a monitor records
// every frame start, RX word and DONE. Each transaction is then compared with
// what the frame/abort rules predict from the words that were offered.

module tb_sc_spi_seq;

  localparam int unsigned NFW = 8;

  logic           SPICLK = 1'b0;
  logic           SYSRSTB;
  logic           REQ;
  logic [NFW-1:0] NFRAME;
  logic [4:0]     FBITS;
  logic           ACK;
  logic           BUSY;
  logic           DONE;
  logic           ABORT;
  logic           ABORTED;
  logic           TXVALID = 1'b0;
  logic [31:0]    TXWDATA = 32'h0;
  logic           TXREADY;
  logic           RXOVALID;
  logic [31:0]    RXODATA;
  logic           SPISTART;
  logic           SPIBUSY = 1'b0;
  logic           CSEXTEND;
  logic [31:0]    TXDATA;
  logic [8:0]     DWIDTH;
  logic [31:0]    RXDATA = 32'h0;
  logic           RXVALID = 1'b0;

  sc_spi_seq #(.NFW(NFW)) dut (
    .SPICLK   (SPICLK),
    .SYSRSTB  (SYSRSTB),
    .REQ      (REQ),
    .NFRAME   (NFRAME),
    .FBITS    (FBITS),
    .ACK      (ACK),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ABORT    (ABORT),
    .ABORTED  (ABORTED),
    .TXVALID  (TXVALID),
    .TXWDATA  (TXWDATA),
    .TXREADY  (TXREADY),
    .RXOVALID (RXOVALID),
    .RXODATA  (RXODATA),
    .SPISTART (SPISTART),
    .SPIBUSY  (SPIBUSY),
    .CSEXTEND (CSEXTEND),
    .TXDATA   (TXDATA),
    .DWIDTH   (DWIDTH),
    .RXDATA   (RXDATA),
    .RXVALID  (RXVALID)
  );

  always #5 SPICLK = ~SPICLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: registered outputs sampled 1ns after the active edge.
  int          ack_cnt = 0;
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          busy_gap = 0;
  int          abt_val = 0;
  logic [31:0] st_data_q[$];
  logic        st_cs_q[$];
  logic [31:0] rx_out_q[$];

  always @(posedge SPICLK) begin
    #1;
    if (ACK) ack_cnt++;
    if (SPISTART) begin
      start_cnt++;
      st_data_q.push_back(TXDATA);
      st_cs_q.push_back(CSEXTEND);
    end
    if (RXOVALID) rx_out_q.push_back(RXODATA);
    if (DONE) begin
      done_cnt++;
      abt_val = int'(ABORTED);
      if (!BUSY) busy_gap++;
    end
  end

  // TX word source: presents tx_words[tx_idx] while enabled.
  logic [31:0] tx_words[$];
  int          tx_idx = 0;
  int          hs_cnt = 0;
  bit          hs_prev = 1'b0;
  bit          tx_en = 1'b0;

  always @(negedge SPICLK) begin
    #1;
    if (hs_prev) tx_idx++;
    if (tx_en && (tx_idx < tx_words.size())) begin
      TXVALID = 1'b1;
      TXWDATA = tx_words[tx_idx];
    end else begin
      TXVALID = 1'b0;
    end
    #1;
    hs_prev = TXVALID && TXREADY;
    if (hs_prev) hs_cnt++;
  end

  // Behavioural SPI engine: random start/busy latency, RX word = ~TX word,
  // delivered 0..3 cycles after busy falls.
  typedef struct {
    int          due;
    logic [31:0] d;
  } rx_item_t;

  rx_item_t    rxq[$];
  int          eng_st = 0;
  int          eng_cnt = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          inj_req = 0;
  int          inj_done = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_d = 32'h0;
  logic [31:0] cur_d = 32'h0;

  always @(posedge SPICLK) begin
    int due;
    #2;
    cyc++;
    if (!SYSRSTB) begin
      eng_st = 0;
      pend = 1'b0;
      rxq.delete();
      SPIBUSY = 1'b0;
      RXVALID = 1'b0;
    end else begin
      RXVALID = 1'b0;
      if (SPISTART) begin
        pend = 1'b1;
        pend_d = TXDATA;
      end
      case (eng_st)
        0: if (pend) begin
             pend = 1'b0;
             cur_d = pend_d;
             eng_cnt = int'($urandom_range(0, 2));
             eng_st = 1;
           end
        1: if (eng_cnt == 0) begin
             SPIBUSY = 1'b1;
             eng_cnt = int'($urandom_range(1, 4));
             eng_st = 2;
           end else eng_cnt--;
        2: if (eng_cnt == 0) begin
             SPIBUSY = 1'b0;
             due = cyc + int'($urandom_range(0, 3));
             if (due <= last_due) due = last_due + 1;
             last_due = due;
             rxq.push_back('{due, ~cur_d});
             eng_st = 0;
           end else eng_cnt--;
        default: eng_st = 0;
      endcase
      if (inj_req != inj_done) begin
        inj_done++;
        RXVALID = 1'b1;
        RXDATA = 32'hDEAD_BEEF;
      end else if ((rxq.size() > 0) && (rxq[0].due <= cyc)) begin
        RXVALID = 1'b1;
        RXDATA = rxq[0].d;
        void'(rxq.pop_front());
      end
    end
  end

  // Snapshots taken at the start of each transaction.
  int b_start, b_rx, b_done, b_hs, b_ack, b_idx, b_gap;

  task automatic begin_txn(input int n, input int fb);
    b_start = start_cnt;
    b_rx    = rx_out_q.size();
    b_done  = done_cnt;
    b_hs    = hs_cnt;
    b_ack   = ack_cnt;
    b_idx   = tx_idx;
    b_gap   = busy_gap;
    @(negedge SPICLK);
    REQ = 1'b1;
    NFRAME = NFW'(n);
    FBITS = 5'(fb);
    @(negedge SPICLK);
    REQ = 1'b0;
    check("ack_latency", 32'(ack_cnt - b_ack), 32'd1);
    check("busy_on_accept", 32'(BUSY), 32'd1);
    check("dwidth", 32'(DWIDTH), 32'(fb));
  endtask

  // Expected outcome: frames 0..frames-1 carry consecutive offered words,
  // CSEXTEND is high on every frame except frame NFRAME, RX = ~TX in order.
  task automatic end_txn(input int n, input int frames, input int ab);
    int w;
    w = 0;
    while ((done_cnt == b_done) && (w < 8000)) begin
      @(negedge SPICLK);
      w++;
    end
    repeat (3) @(negedge SPICLK);
    check("done_count", 32'(done_cnt - b_done), 32'd1);
    check("aborted", 32'(abt_val), 32'(ab));
    check("busy_during_done", 32'(busy_gap - b_gap), 32'd0);
    check("busy_after_done", 32'(BUSY), 32'd0);
    check("cs_after_done", 32'(CSEXTEND), 32'd0);
    check("ack_once", 32'(ack_cnt - b_ack), 32'd1);
    check("frames", 32'(start_cnt - b_start), 32'(frames));
    check("tx_handshakes", 32'(hs_cnt - b_hs), 32'(frames));
    check("rx_words", 32'(rx_out_q.size() - b_rx), 32'(frames));
    for (int i = 0; i < frames; i++) begin
      if ((b_start + i < st_data_q.size()) && (b_idx + i < tx_words.size())) begin
        check($sformatf("txdata_f%0d", i), st_data_q[b_start + i], tx_words[b_idx + i]);
        check($sformatf("csextend_f%0d", i), 32'(st_cs_q[b_start + i]), 32'(i != n));
      end
      if ((b_rx + i < rx_out_q.size()) && (b_idx + i < tx_words.size())) begin
        check($sformatf("rxdata_f%0d", i), rx_out_q[b_rx + i], ~tx_words[b_idx + i]);
      end
    end
  endtask

  task automatic wait_hs(input int target);
    int w;
    w = 0;
    while (((hs_cnt - b_hs) < target) && (w < 500)) begin
      @(negedge SPICLK);
      w++;
    end
  endtask

  task automatic wait_rx(input int target);
    int w;
    w = 0;
    while (((rx_out_q.size() - b_rx) < target) && (w < 500)) begin
      @(negedge SPICLK);
      w++;
    end
  endtask

  task automatic wait_frame_busy(input int frame);
    int w;
    w = 0;
    while (!(((start_cnt - b_start) == frame + 1) && SPIBUSY) && (w < 4000)) begin
      @(negedge SPICLK);
      w++;
    end
  endtask

  task automatic run_txn(input int n, input int fb, input int ak);
    tx_en = 1'b1;
    begin_txn(n, fb);
    if (ak >= 0) begin
      wait_frame_busy(ak);
      @(negedge SPICLK);
      ABORT = 1'b1;
      @(negedge SPICLK);
      ABORT = 1'b0;
    end
    end_txn(n, (ak >= 0) ? ak + 1 : n + 1, (ak >= 0) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got 0x00000000 expected 0x00000001");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, ak, base;
    SYSRSTB = 1'b0;
    REQ = 1'b0;
    NFRAME = '0;
    FBITS = '0;
    ABORT = 1'b0;
    repeat (2) @(negedge SPICLK);
    check("reset_ctl", 32'({ACK, BUSY, DONE, ABORTED, TXREADY, RXOVALID, SPISTART, CSEXTEND}), 32'd0);
    check("reset_txdata", TXDATA, 32'd0);
    check("reset_dwidth", 32'(DWIDTH), 32'd0);
    SYSRSTB = 1'b1;
    @(negedge SPICLK);

    // RXVALID while idle must not be forwarded.
    base = rx_out_q.size();
    inj_req++;
    repeat (4) @(negedge SPICLK);
    check("idle_rx_ignored", 32'(rx_out_q.size() - base), 32'd0);

    // Single frame.
    tx_words.push_back(32'h0000_00A5);
    run_txn(0, 7, -1);

    // Four-frame burst with fixed words.
    tx_words.push_back(32'h1111_1111);
    tx_words.push_back(32'h2222_2222);
    tx_words.push_back(32'h3333_3333);
    tx_words.push_back(32'h4444_4444);
    run_txn(3, 31, -1);

    // TX starvation before frame 1.
    tx_words.push_back($urandom);
    tx_words.push_back($urandom);
    tx_en = 1'b1;
    begin_txn(1, 12);
    wait_hs(1);
    tx_en = 1'b0;
    wait_rx(1);
    repeat (20) @(negedge SPICLK);
    check("starve_no_start", 32'(start_cnt - b_start), 32'd1);
    check("starve_cs_held", 32'(CSEXTEND), 32'd1);
    check("starve_busy", 32'(BUSY), 32'd1);
    tx_en = 1'b1;
    repeat (2) @(negedge SPICLK);
    check("resume_start", 32'(start_cnt - b_start), 32'd2);
    end_txn(1, 2, 0);

    // Abort during frame 2 of 8.
    for (int i = 0; i < 8; i++) tx_words.push_back($urandom);
    run_txn(7, 15, 2);

    // Abort in FETCH together with TXVALID: nothing consumed.
    for (int i = 0; i < 4; i++) tx_words.push_back($urandom);
    tx_en = 1'b1;
    begin_txn(3, 20);
    wait_hs(1);
    tx_en = 1'b0;
    wait_rx(1);
    repeat (3) @(negedge SPICLK);
    ABORT = 1'b1;
    tx_en = 1'b1;
    #2;
    check("fetch_abort_valid", 32'(TXVALID), 32'd1);
    check("fetch_abort_ready", 32'(TXREADY), 32'd0);
    @(negedge SPICLK);
    ABORT = 1'b0;
    tx_en = 1'b0;
    end_txn(3, 1, 1);

    // Reset during frame 1 of 4, then a clean transaction.
    for (int i = 0; i < 4; i++) tx_words.push_back($urandom | 32'h1);
    tx_en = 1'b1;
    begin_txn(3, 9);
    wait_frame_busy(1);
    @(negedge SPICLK);
    SYSRSTB = 1'b0;
    #1;
    check("midrst_ctl", 32'({ACK, BUSY, DONE, ABORTED, TXREADY, RXOVALID, SPISTART, CSEXTEND}), 32'd0);
    check("midrst_txdata", TXDATA, 32'd0);
    check("midrst_rxodata", RXODATA, 32'd0);
    check("midrst_dwidth", 32'(DWIDTH), 32'd0);
    repeat (3) @(negedge SPICLK);
    SYSRSTB = 1'b1;
    repeat (3) @(negedge SPICLK);
    check("midrst_no_done", 32'(done_cnt - b_done), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    for (int i = 0; i < 3; i++) tx_words.push_back($urandom);
    run_txn(2, 3, -1);

    // Randomized transactions, some aborted.
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(0, 6));
      ak = ((($urandom % 3) == 0) && (n > 0)) ? int'($urandom_range(0, n - 1)) : -1;
      for (int i = 0; i <= n; i++) tx_words.push_back($urandom);
      run_txn(n, int'($urandom_range(0, 31)), ak);
    end

    // Maximum length: 2^NFW frames.
    for (int i = 0; i < 256; i++) tx_words.push_back($urandom);
    run_txn(255, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_spi_seq.md
Name: sc_spi_seq

Overview:
- Multi-frame transaction sequencer in front of the SPI protocol controller. It runs one host transaction as NFRAME+1 back-to-back frames.
- Per frame it pulls one TX word from a valid/ready stream, pulses SPISTART, and holds CSEXTEND so chip select stays asserted between frames.
- It forwards each received word and signals DONE when the last RX word has been forwarded.
- It sits between the register/bus front-end and the protocol engine, in the SPICLK domain.

Parameters:
- NFW, 8, width of the frame count field NFRAME. A transaction is 1..2^NFW frames.

Ports:
- SPICLK  in  1  system/SPI clock; all logic is posedge.
- SYSRSTB  in  1  reset, asynchronous assert, active-low.
- REQ  in  1  transaction request; level, sampled in IDLE.
- NFRAME  in  NFW  frames minus one; latched on accept.
- FBITS  in  5  bits per frame minus one (0..31); latched on accept.
- ACK  out  1  one-cycle pulse: request accepted.
- BUSY  out  1  high from accept until DONE, inclusive.
- DONE  out  1  one-cycle pulse: transaction complete.
- ABORT  in  1  stop after the current frame.
- ABORTED  out  1  qualifies DONE: transaction ended by ABORT.
- TXVALID  in  1  TX word available.
- TXWDATA  in  32  TX word.
- TXREADY  out  1  TX word consumed this cycle.
- RXOVALID  out  1  one-cycle pulse: RXODATA valid.
- RXODATA  out  32  received word.
- SPISTART  out  1  to engine: frame start.
- SPIBUSY  in  1  from engine: busy.
- CSEXTEND  out  1  to engine: keep chip select asserted after the frame.
- TXDATA  out  32  to engine: frame data.
- DWIDTH  out  9  to engine: {4'b0, FBITS latched}.
- RXDATA  in  32  from engine.
- RXVALID  in  1  from engine: one pulse per frame, since frames are ≤32 bits.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; latched FBITS/NFRAME 0.
- States: IDLE, FETCH, START, WBSY, RUN, DRAIN.
- IDLE
  - REQ=1 and SPIBUSY=0: latch NFRAME/FBITS, set txcnt=rxcnt=0, pulse ACK, set BUSY=1, go to FETCH.
  - REQ is ignored while SPIBUSY=1.
- FETCH
  - TXVALID=1: TXREADY=1 (combinational, this cycle only), register TXWDATA into TXDATA, go to START.
  - TXVALID=0: wait indefinitely. CSEXTEND stays as driven, so CS stays low between frames.
  - ABORT=1 with TXVALID=0: go to DRAIN with the abort flag set.
  - If ABORT and TXVALID are both 1, ABORT wins: no word is consumed.
- START
  - SPISTART=1 for exactly one cycle.
  - CSEXTEND = (txcnt != NFRAME latched) and not abort flag.
  - Go to WBSY.
- WBSY: wait for SPIBUSY=1, then go to RUN.
- RUN
  - Wait for SPIBUSY=0, then increment txcnt.
  - If txcnt was NFRAME or the abort flag is set, go to DRAIN; else go to FETCH.
- CSEXTEND
  - Registered; held constant from START until the next START or DRAIN exit.
  - Cleared on the last frame so the engine releases CS after CSHOLD.
- ABORT in START/WBSY/RUN: set the abort flag sticky; the current frame completes normally.
- RX path, in any state other than IDLE:
  - RXVALID=1: RXODATA<=RXDATA, RXOVALID<=1 next cycle (1-cycle latency), rxcnt++.
  - There is no backpressure; the consumer must accept every pulse.
- DRAIN
  - Wait until rxcnt == txcnt.
  - Then DONE=1 for one cycle, ABORTED=abort flag, BUSY=0 the following cycle, clear CSEXTEND and the abort flag, go to IDLE.
  - If rxcnt==txcnt already on entry, DONE follows on the next cycle.
- RXVALID in IDLE is ignored.
- Counter widths are NFW+1 bits, so NFRAME=all-ones (2^NFW frames) does not wrap.
- Reset mid-transaction: every output returns to its reset value immediately; no DONE is issued.

Test Plan:
- Single frame: NFRAME=0, FBITS=7, TXWDATA=0x000000A5 already valid.
  - ACK one cycle after REQ; one SPISTART with CSEXTEND=0.
  - RXOVALID pulse carries the engine RXDATA; DONE=1, ABORTED=0; BUSY low afterwards.
- Burst: NFRAME=3, FBITS=31, words 0x11111111..0x44444444.
  - Four SPISTART pulses; CSEXTEND=1 on frames 0-2 and 0 on frame 3; CS stays low throughout.
  - Four RXOVALID pulses in order; a single DONE.
- TX starvation: NFRAME=1, TXVALID dropped for 20 cycles before frame 1.
  - Sequencer holds in FETCH with CSEXTEND=1 and no SPISTART.
  - Frame 1 starts two cycles after TXVALID returns.
- Abort: NFRAME=7, ABORT pulsed during frame 2 RUN.
  - Frame 2 completes; no further SPISTART; exactly 3 TXREADY and 3 RXOVALID pulses.
  - DONE with ABORTED=1; CSEXTEND=0.
- Abort in FETCH with TXVALID=1 in the same cycle: no TXREADY; DONE/ABORTED after RX drain.
- SYSRSTB asserted during RUN of frame 1 of 4: all outputs 0 asynchronously. After release, a new REQ is accepted normally with counters restarting at 0.
